// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code consumer: prefix codes,
// sequencer state encodings and the byte-class enum.
package ps2_pkg;

  localparam logic [7:0] PS2_CODE_EXT   = 8'hE0;
  localparam logic [7:0] PS2_CODE_BREAK = 8'hF0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_POP  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  typedef enum logic [1:0] {
    CLS_EXT = 2'd0,
    CLS_BRK = 2'd1,
    CLS_KEY = 2'd2
  } byte_cls_e;

endpackage

// File: rtl/ps2_code_classify.sv
// Combinational scan-code byte classifier: extended prefix, break prefix or key code.
module ps2_code_classify
  import ps2_pkg::*;
(
  input  logic [7:0] i_byte,
  output byte_cls_e  o_cls
);

  always_comb begin
    o_cls = CLS_KEY;
    if (i_byte == PS2_CODE_EXT) begin
      o_cls = CLS_EXT;
    end else if (i_byte == PS2_CODE_BREAK) begin
      o_cls = CLS_BRK;
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 receiver FIFO consumer: pops bytes, parses E0/F0 sequences, tracks the
// held key, pulses press/release and counts presses modulo COUNT_MAX+1.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int COUNT_MAX = 99,
  parameter int COUNT_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_clr_n,
  input  logic [7:0]         i_ps2_data,
  input  logic               i_ps2_ready,
  input  logic               i_ps2_overflow,
  output logic               o_nextdata_n,
  output logic [7:0]         o_key_code,
  output logic               o_key_ext,
  output logic               o_key_valid,
  output logic               o_key_press,
  output logic               o_key_release,
  output logic [COUNT_W-1:0] o_press_count,
  output logic               o_overflow_err
);

  // Handshake: a byte is taken when i_ps2_ready=1 in S_IDLE; o_nextdata_n is then
  // low for exactly one cycle (S_POP) and high for one more (S_GAP) before the
  // next i_ps2_ready sample, giving the receiver time to advance its pointer.

  logic [1:0]         r_state;
  logic               r_nextdata_n;
  logic [7:0]         r_key_code;
  logic               r_key_ext;
  logic               r_key_valid;
  logic               r_key_press;
  logic               r_key_release;
  logic [COUNT_W-1:0] r_press_count;
  logic               r_ovf_err;
  logic               r_brk;
  logic               r_ext;

  byte_cls_e          w_cls;
  logic               w_brk_eff;
  logic               w_ext_eff;
  logic               w_match;
  logic [COUNT_W-1:0] w_count_next;

  ps2_code_classify u_classify (
    .i_byte (i_ps2_data),
    .o_cls  (w_cls)
  );

  // An overflow in the capture cycle discards any pending prefix first.
  assign w_brk_eff = r_brk & ~i_ps2_overflow;
  assign w_ext_eff = r_ext & ~i_ps2_overflow;
  assign w_match   = r_key_valid && (i_ps2_data == r_key_code) && (w_ext_eff == r_key_ext);

  assign w_count_next = (r_press_count == COUNT_W'(COUNT_MAX)) ? '0
                                                                : r_press_count + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_state       <= S_IDLE;
      r_nextdata_n  <= 1'b1;
      r_key_code    <= 8'h00;
      r_key_ext     <= 1'b0;
      r_key_valid   <= 1'b0;
      r_key_press   <= 1'b0;
      r_key_release <= 1'b0;
      r_press_count <= '0;
      r_ovf_err     <= 1'b0;
      r_brk         <= 1'b0;
      r_ext         <= 1'b0;
    end else begin
      r_key_press   <= 1'b0;
      r_key_release <= 1'b0;
      if (i_ps2_overflow) begin
        r_ovf_err <= 1'b1;
        r_brk     <= 1'b0;
        r_ext     <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_ps2_ready) begin
            r_state      <= S_POP;
            r_nextdata_n <= 1'b0;
            unique case (w_cls)
              CLS_EXT: r_ext <= 1'b1;
              CLS_BRK: r_brk <= 1'b1;
              default: begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
                if (w_brk_eff) begin
                  if (w_match) begin
                    r_key_valid   <= 1'b0;
                    r_key_release <= 1'b1;
                  end
                end else if (!w_match) begin
                  r_key_code    <= i_ps2_data;
                  r_key_ext     <= w_ext_eff;
                  r_key_valid   <= 1'b1;
                  r_key_press   <= 1'b1;
                  r_press_count <= w_count_next;
                end
              end
            endcase
          end
        end
        S_POP: begin
          r_state      <= S_GAP;
          r_nextdata_n <= 1'b1;
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state      <= S_IDLE;
          r_nextdata_n <= 1'b1;
        end
      endcase
    end
  end

  assign o_nextdata_n   = r_nextdata_n;
  assign o_key_code     = r_key_code;
  assign o_key_ext      = r_key_ext;
  assign o_key_valid    = r_key_valid;
  assign o_key_press    = r_key_press;
  assign o_key_release  = r_key_release;
  assign o_press_count  = r_press_count;
  assign o_overflow_err = r_ovf_err;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: emulates the receiver FIFO head one byte at a
// time and checks decode results, pulses, counter wrap, overflow and reset.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       i_clr_n = 1'b0;
  logic [7:0] i_ps2_data = 8'h00;
  logic       i_ps2_ready = 1'b0;
  logic       i_ps2_overflow = 1'b0;
  logic       o_nextdata_n;
  logic [7:0] o_key_code;
  logic       o_key_ext;
  logic       o_key_valid;
  logic       o_key_press;
  logic       o_key_release;
  logic [7:0] o_press_count;
  logic       o_overflow_err;

  int n_pass = 0;
  int n_total = 0;
  int n_press = 0;
  int n_release = 0;
  bit both_seen = 1'b0;

  always #5 clk = ~clk;

  ps2_key_ctrl #(.COUNT_MAX(99), .COUNT_W(8)) dut (
    .i_clk          (clk),
    .i_clr_n        (i_clr_n),
    .i_ps2_data     (i_ps2_data),
    .i_ps2_ready    (i_ps2_ready),
    .i_ps2_overflow (i_ps2_overflow),
    .o_nextdata_n   (o_nextdata_n),
    .o_key_code     (o_key_code),
    .o_key_ext      (o_key_ext),
    .o_key_valid    (o_key_valid),
    .o_key_press    (o_key_press),
    .o_key_release  (o_key_release),
    .o_press_count  (o_press_count),
    .o_overflow_err (o_overflow_err)
  );

  // Pulse monitor: a pulse wider than one cycle is counted twice.
  always @(negedge clk) begin
    if (o_key_press) n_press++;
    if (o_key_release) n_release++;
    if (o_key_press && o_key_release) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    i_clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_clr_n = 1'b1;
  endtask

  // Present one byte at the FIFO head until popped, then wait out S_POP/S_GAP.
  task automatic send_byte(input logic [7:0] b, input logic ovf = 1'b0, input bit chk_pop = 1'b0);
    bit seen = 1'b0;
    i_ps2_data     = b;
    i_ps2_ready    = 1'b1;
    i_ps2_overflow = ovf;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!o_nextdata_n) begin
        seen = 1'b1;
        break;
      end
    end
    i_ps2_ready    = 1'b0;
    i_ps2_overflow = 1'b0;
    if (!seen) check("pop_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (chk_pop) check("pop_one_cycle", 32'(o_nextdata_n), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_nextdata_n"}, 32'(o_nextdata_n), 32'd1);
    check({tag, "_code"}, 32'(o_key_code), 32'h00);
    check({tag, "_ext"}, 32'(o_key_ext), 32'd0);
    check({tag, "_valid"}, 32'(o_key_valid), 32'd0);
    check({tag, "_press"}, 32'(o_key_press), 32'd0);
    check({tag, "_release"}, 32'(o_key_release), 32'd0);
    check({tag, "_count"}, 32'(o_press_count), 32'd0);
    check({tag, "_ovf"}, 32'(o_overflow_err), 32'd0);
  endtask

  initial begin
    int p0;
    int r0;
    bit seen;
    logic [7:0] k;

    @(posedge clk);
    do_reset();
    check_all_zero("reset");

    // Single make
    p0 = n_press;
    send_byte(8'h1C, 1'b0, 1'b1);
    check("make_code", 32'(o_key_code), 32'h1C);
    check("make_valid", 32'(o_key_valid), 32'd1);
    check("make_press_pulses", 32'(n_press - p0), 32'd1);
    check("make_count", 32'(o_press_count), 32'd1);

    // Typematic repeats then break
    p0 = n_press;
    r0 = n_release;
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("rep_count", 32'(o_press_count), 32'd1);
    check("rep_press_pulses", 32'(n_press - p0), 32'd0);
    check("rep_release_pulses", 32'(n_release - r0), 32'd1);
    check("rep_valid", 32'(o_key_valid), 32'd0);
    check("rep_code", 32'(o_key_code), 32'h1C);

    // Extended make, non-extended break must be ignored
    send_byte(8'hE0);
    send_byte(8'h75);
    check("ext_make_ext", 32'(o_key_ext), 32'd1);
    check("ext_make_count", 32'(o_press_count), 32'd2);
    r0 = n_release;
    send_byte(8'hF0);
    send_byte(8'h75);
    check("ext_mismatch_valid", 32'(o_key_valid), 32'd1);
    check("ext_mismatch_release", 32'(n_release - r0), 32'd0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("ext_break_release", 32'(n_release - r0), 32'd1);
    check("ext_break_valid", 32'(o_key_valid), 32'd0);
    check("ext_break_ext", 32'(o_key_ext), 32'd1);
    check("ext_break_code", 32'(o_key_code), 32'h75);

    // 100 make/break pairs from a zero count: wrap after COUNT_MAX
    do_reset();
    p0 = n_press;
    for (int i = 1; i <= 100; i++) begin
      k = (i % 2 == 1) ? 8'h1C : 8'h32;
      send_byte(k);
      if (i == 1) check("wrap_first", 32'(o_press_count), 32'd1);
      if (i == 99) check("wrap_99th", 32'(o_press_count), 32'd99);
      if (i == 100) check("wrap_100th", 32'(o_press_count), 32'd0);
      check("wrap_le_max", 32'(o_press_count <= 8'd99), 32'd1);
      send_byte(8'hF0);
      send_byte(k);
    end
    check("wrap_press_pulses", 32'(n_press - p0), 32'd100);
    check("wrap_valid", 32'(o_key_valid), 32'd0);

    // Overflow clears a pending break; 1C then decodes as a make
    send_byte(8'hF0);
    i_ps2_overflow = 1'b1;
    @(posedge clk);
    #1;
    i_ps2_overflow = 1'b0;
    check("ovf_set", 32'(o_overflow_err), 32'd1);
    p0 = n_press;
    send_byte(8'h1C);
    check("ovf_make_press", 32'(n_press - p0), 32'd1);
    check("ovf_make_count", 32'(o_press_count), 32'd1);
    check("ovf_make_valid", 32'(o_key_valid), 32'd1);
    check("ovf_sticky", 32'(o_overflow_err), 32'd1);

    // Overflow in the capture cycle drops the E0 prefix
    send_byte(8'hE0);
    send_byte(8'h75, 1'b1);
    check("ovf_cap_code", 32'(o_key_code), 32'h75);
    check("ovf_cap_ext", 32'(o_key_ext), 32'd0);
    check("ovf_cap_count", 32'(o_press_count), 32'd2);

    // Back-to-back E0 keeps ext set; a new key replaces the held one
    send_byte(8'hE0);
    send_byte(8'hE0);
    send_byte(8'h75);
    check("e0e0_ext", 32'(o_key_ext), 32'd1);
    check("e0e0_count", 32'(o_press_count), 32'd3);

    // Reset asserted while in S_POP
    i_ps2_data  = 8'h1C;
    i_ps2_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!o_nextdata_n) begin
        seen = 1'b1;
        break;
      end
    end
    i_ps2_ready = 1'b0;
    check("pop_rst_reached", 32'(seen), 32'd1);
    i_clr_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("pop_rst");
    i_clr_n = 1'b1;

    check("never_both_pulses", 32'(both_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
